// File: rtl/rsa_job_sequencer_if.sv
// rtl/rsa_job_sequencer_if.sv - requester, response and control-unit signals of the RSA job sequencer
// master is the sequencer side; slave is the requester/consumer/control-unit side.
interface rsa_job_sequencer_if #(
  parameter int WIDTH = 128
);
  logic               req0_valid;
  logic               req0_ready;
  logic [WIDTH-1:0]   req0_p;
  logic [WIDTH-1:0]   req0_q;
  logic               req0_mode;
  logic [2*WIDTH-1:0] req0_msg;
  logic               req1_valid;
  logic               req1_ready;
  logic [WIDTH-1:0]   req1_p;
  logic [WIDTH-1:0]   req1_q;
  logic               req1_mode;
  logic [2*WIDTH-1:0] req1_msg;
  logic               rsp_valid;
  logic               rsp_ready;
  logic               rsp_id;
  logic [2*WIDTH-1:0] rsp_msg;
  logic               rsp_err;
  logic [WIDTH-1:0]   ctl_p;
  logic [WIDTH-1:0]   ctl_q;
  logic               ctl_encrypt_decrypt;
  logic [2*WIDTH-1:0] ctl_msg_in;
  logic               ctl_reset_inverter;
  logic               ctl_reset_mod_exp;
  logic               ctl_inverter_finish;
  logic               ctl_mod_exp_finish;
  logic [2*WIDTH-1:0] ctl_msg_out;
  logic               busy;

  modport master (
    input  req0_valid, req0_p, req0_q, req0_mode, req0_msg,
    input  req1_valid, req1_p, req1_q, req1_mode, req1_msg,
    input  rsp_ready, ctl_inverter_finish, ctl_mod_exp_finish, ctl_msg_out,
    output req0_ready, req1_ready, rsp_valid, rsp_id, rsp_msg, rsp_err,
    output ctl_p, ctl_q, ctl_encrypt_decrypt, ctl_msg_in,
    output ctl_reset_inverter, ctl_reset_mod_exp, busy
  );

  modport slave (
    output req0_valid, req0_p, req0_q, req0_mode, req0_msg,
    output req1_valid, req1_p, req1_q, req1_mode, req1_msg,
    output rsp_ready, ctl_inverter_finish, ctl_mod_exp_finish, ctl_msg_out,
    input  req0_ready, req1_ready, rsp_valid, rsp_id, rsp_msg, rsp_err,
    input  ctl_p, ctl_q, ctl_encrypt_decrypt, ctl_msg_in,
    input  ctl_reset_inverter, ctl_reset_mod_exp, busy
  );
endinterface

// File: rtl/rsa_job_sequencer.sv
// rtl/rsa_job_sequencer.sv - two-requester RSA job sequencer with key reuse
// Optional per-phase watchdog enabled by defining RSA_SEQ_TIMEOUT_EN.
module rsa_job_sequencer #(
  parameter int WIDTH          = 128,
  parameter int TIMEOUT_CYCLES = 65536
) (
  input  logic                 clk,
  input  logic                 reset,
  rsa_job_sequencer_if.master  bus
);

  typedef enum logic [2:0] {
    IDLE, INV_PULSE, INV_WAIT, EXP_PULSE, EXP_WAIT, RESP
  } state_t;

  state_t             state_q, state_d;
  logic [1:0]         ready_q, ready_d;
  logic               gnt_q, gnt_d;
  logic               last_q, last_d;
  logic               armed_q, armed_d;
  logic               key_valid_q, key_valid_d;
  logic [WIDTH-1:0]   key_p_q, key_p_d, key_q_q, key_q_d;
  logic [WIDTH-1:0]   ctl_p_q, ctl_p_d, ctl_q_q, ctl_q_d;
  logic               ctl_mode_q, ctl_mode_d;
  logic [2*WIDTH-1:0] ctl_msg_q, ctl_msg_d;
  logic               rst_inv_q, rst_inv_d, rst_exp_q, rst_exp_d;
  logic               rsp_valid_q, rsp_valid_d;
  logic               rsp_id_q, rsp_id_d;
  logic [2*WIDTH-1:0] rsp_msg_q, rsp_msg_d;
  logic               busy_q, busy_d;

  logic [1:0]         valid;
  logic               pick;
  logic [WIDTH-1:0]   sel_p, sel_q;
  logic               key_hit;
  logic               timed_out;
  logic               abort;

  assign valid   = {bus.req1_valid, bus.req0_valid};
  // Tie goes to the requester that was not granted last.
  assign pick    = (valid == 2'b11) ? ~last_q : valid[1];
  assign sel_p   = gnt_q ? bus.req1_p : bus.req0_p;
  assign sel_q   = gnt_q ? bus.req1_q : bus.req0_q;
  assign key_hit = key_valid_q && (sel_p == key_p_q) && (sel_q == key_q_q);

`ifdef RSA_SEQ_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             rsp_err_q, rsp_err_d;

  assign timed_out = (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));
  assign bus.rsp_err = rsp_err_q;
`else
  assign timed_out = 1'b0;
  assign bus.rsp_err = 1'b0;
`endif

  always_comb begin
    state_d     = state_q;
    ready_d     = 2'b00;
    gnt_d       = gnt_q;
    last_d      = last_q;
    armed_d     = 1'b0;
    key_valid_d = key_valid_q;
    key_p_d     = key_p_q;
    key_q_d     = key_q_q;
    ctl_p_d     = ctl_p_q;
    ctl_q_d     = ctl_q_q;
    ctl_mode_d  = ctl_mode_q;
    ctl_msg_d   = ctl_msg_q;
    rsp_valid_d = rsp_valid_q;
    rsp_id_d    = rsp_id_q;
    rsp_msg_d   = rsp_msg_q;
    abort       = 1'b0;

    case (state_q)
      IDLE: begin
        // The ready pulse is registered, so the job is taken one cycle after arbitration.
        if (ready_q != 2'b00) begin
          if (valid[gnt_q]) begin
            ctl_p_d    = sel_p;
            ctl_q_d    = sel_q;
            ctl_mode_d = gnt_q ? bus.req1_mode : bus.req0_mode;
            ctl_msg_d  = gnt_q ? bus.req1_msg : bus.req0_msg;
            last_d     = gnt_q;
            state_d    = key_hit ? EXP_PULSE : INV_PULSE;
          end
        end else if (valid != 2'b00) begin
          gnt_d   = pick;
          ready_d = pick ? 2'b10 : 2'b01;
        end
      end
      INV_PULSE: state_d = INV_WAIT;
      INV_WAIT: begin
        if (armed_q && bus.ctl_inverter_finish) begin
          state_d     = EXP_PULSE;
          key_valid_d = 1'b1;
          key_p_d     = ctl_p_q;
          key_q_d     = ctl_q_q;
        end else if (timed_out) begin
          abort = 1'b1;
        end else begin
          armed_d = 1'b1;
        end
      end
      EXP_PULSE: state_d = EXP_WAIT;
      EXP_WAIT: begin
        if (armed_q && bus.ctl_mod_exp_finish) begin
          state_d     = RESP;
          rsp_valid_d = 1'b1;
          rsp_id_d    = gnt_q;
          rsp_msg_d   = bus.ctl_msg_out;
        end else if (timed_out) begin
          abort = 1'b1;
        end else begin
          armed_d = 1'b1;
        end
      end
      RESP: begin
        if (bus.rsp_ready) begin
          rsp_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    if (abort) begin
      state_d     = RESP;
      rsp_valid_d = 1'b1;
      rsp_id_d    = gnt_q;
      rsp_msg_d   = '0;
      key_valid_d = 1'b0;
    end

`ifdef RSA_SEQ_TIMEOUT_EN
    rsp_err_d = rsp_err_q;
    if (state_q != RESP && state_d == RESP) rsp_err_d = abort;
    cnt_d = ((state_q == INV_WAIT || state_q == EXP_WAIT) && state_d == state_q)
          ? cnt_q + CNT_W'(1) : '0;
`endif

    busy_d    = (state_d != IDLE);
    rst_inv_d = (state_d == INV_PULSE);
    rst_exp_d = (state_d == EXP_PULSE);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      ready_q     <= 2'b00;
      gnt_q       <= 1'b0;
      last_q      <= 1'b1;
      armed_q     <= 1'b0;
      key_valid_q <= 1'b0;
      key_p_q     <= '0;
      key_q_q     <= '0;
      ctl_p_q     <= '0;
      ctl_q_q     <= '0;
      ctl_mode_q  <= 1'b0;
      ctl_msg_q   <= '0;
      rst_inv_q   <= 1'b0;
      rst_exp_q   <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_id_q    <= 1'b0;
      rsp_msg_q   <= '0;
      busy_q      <= 1'b0;
`ifdef RSA_SEQ_TIMEOUT_EN
      cnt_q       <= '0;
      rsp_err_q   <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      ready_q     <= ready_d;
      gnt_q       <= gnt_d;
      last_q      <= last_d;
      armed_q     <= armed_d;
      key_valid_q <= key_valid_d;
      key_p_q     <= key_p_d;
      key_q_q     <= key_q_d;
      ctl_p_q     <= ctl_p_d;
      ctl_q_q     <= ctl_q_d;
      ctl_mode_q  <= ctl_mode_d;
      ctl_msg_q   <= ctl_msg_d;
      rst_inv_q   <= rst_inv_d;
      rst_exp_q   <= rst_exp_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_id_q    <= rsp_id_d;
      rsp_msg_q   <= rsp_msg_d;
      busy_q      <= busy_d;
`ifdef RSA_SEQ_TIMEOUT_EN
      cnt_q       <= cnt_d;
      rsp_err_q   <= rsp_err_d;
`endif
    end
  end

  assign bus.req0_ready          = ready_q[0];
  assign bus.req1_ready          = ready_q[1];
  assign bus.rsp_valid           = rsp_valid_q;
  assign bus.rsp_id              = rsp_id_q;
  assign bus.rsp_msg             = rsp_msg_q;
  assign bus.ctl_p               = ctl_p_q;
  assign bus.ctl_q               = ctl_q_q;
  assign bus.ctl_encrypt_decrypt = ctl_mode_q;
  assign bus.ctl_msg_in          = ctl_msg_q;
  assign bus.ctl_reset_inverter  = rst_inv_q;
  assign bus.ctl_reset_mod_exp   = rst_exp_q;
  assign bus.busy                = busy_q;

endmodule

// File: tb/tb_rsa_job_sequencer.sv
// tb/tb_rsa_job_sequencer.sv - directed bench for rsa_job_sequencer with a latency model of the control unit
module tb_rsa_job_sequencer;
  localparam int W = 128;
  localparam logic [W-1:0]   KP   = 128'd113680897410347;
  localparam logic [W-1:0]   KQ   = 128'd7999808077935876437321;
  localparam logic [W-1:0]   KP2  = 128'd1000003;
  localparam logic [W-1:0]   KQ2  = 128'd999983;
  localparam logic [2*W-1:0] MSG1 = 256'h00262d806a3e18f03ab37b2857e7e100;
  localparam logic [2*W-1:0] MSG2 = 256'h00262d806a3e18f03ab3000000000000;
  localparam logic [2*W-1:0] MSG3 = 256'h0000000000000000000000000000000000000000000000001234abcd5678ef01;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  rsa_job_sequencer_if #(.WIDTH(W)) bus ();

  rsa_job_sequencer #(.WIDTH(W), .TIMEOUT_CYCLES(16)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int inv_pulses = 0, exp_pulses = 0, ready_cycles = 0;
  int last_inv_cyc = 0, last_exp_cyc = 0;
  int lat = 20;
  bit inv_en = 1'b1, exp_en = 1'b1, stale_hold = 1'b0;
  int inv_cnt = 0, exp_cnt = 0, stale_cnt = 0;
  int grant_id, grant_cyc, rsp_cyc, ack_cyc;
  logic rsp_id_seen, rsp_err_seen;
  logic [2*W-1:0] rsp_msg_seen;
  int i0, e0, r0, g_first;

  task automatic check(input string tag, input logic [255:0] got, input logic [255:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %h want %h", tag, got, want);
    end
  endtask

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    if (bus.ctl_reset_inverter) begin inv_pulses++; last_inv_cyc = cyc; end
    if (bus.ctl_reset_mod_exp) begin exp_pulses++; last_exp_cyc = cyc; end
    if (bus.req0_ready || bus.req1_ready) ready_cycles++;
  end

  // Control-unit model: finish flags stay high after completion until the next start pulse.
  always @(negedge clk) begin
    if (reset) begin
      bus.ctl_inverter_finish = 1'b0;
      bus.ctl_mod_exp_finish  = 1'b0;
      bus.ctl_msg_out         = '0;
      inv_cnt = 0; exp_cnt = 0; stale_cnt = 0;
    end else begin
      if (bus.ctl_reset_inverter) begin
        bus.ctl_inverter_finish = 1'b0;
        inv_cnt = lat;
      end else if (inv_cnt > 0) begin
        inv_cnt--;
        if (inv_cnt == 0 && inv_en) bus.ctl_inverter_finish = 1'b1;
      end
      if (bus.ctl_reset_mod_exp) begin
        if (stale_hold) stale_cnt = 2;
        else bus.ctl_mod_exp_finish = 1'b0;
        exp_cnt = lat;
      end else begin
        if (stale_cnt > 0) begin
          stale_cnt--;
          if (stale_cnt == 0) bus.ctl_mod_exp_finish = 1'b0;
        end
        if (exp_cnt > 0) begin
          exp_cnt--;
          if (exp_cnt == 0 && exp_en) begin
            bus.ctl_mod_exp_finish = 1'b1;
            bus.ctl_msg_out = ~bus.ctl_msg_in;
          end
        end
      end
    end
  end

  task automatic send_req(input int id, input logic [W-1:0] p, input logic [W-1:0] q,
                          input logic mode, input logic [2*W-1:0] msg);
    if (id == 0) begin
      bus.req0_p = p; bus.req0_q = q; bus.req0_mode = mode; bus.req0_msg = msg; bus.req0_valid = 1'b1;
    end else begin
      bus.req1_p = p; bus.req1_q = q; bus.req1_mode = mode; bus.req1_msg = msg; bus.req1_valid = 1'b1;
    end
  endtask

  task automatic wait_any();
    int n = 0;
    @(negedge clk);
    while (!(bus.req0_ready || bus.req1_ready) && n < 300) begin @(negedge clk); n++; end
    check("grant_seen", 256'(bus.req0_ready | bus.req1_ready), 256'(1));
    grant_id  = bus.req1_ready ? 1 : 0;
    grant_cyc = cyc;
    @(posedge clk); #1;
    if (grant_id == 0) bus.req0_valid = 1'b0; else bus.req1_valid = 1'b0;
  endtask

  task automatic wait_rsp(input int hold, input logic [2*W-1:0] want_msg);
    int n = 0;
    @(negedge clk);
    while (!bus.rsp_valid && n < 500) begin @(negedge clk); n++; end
    check("rsp_seen", 256'(bus.rsp_valid), 256'(1));
    rsp_cyc = cyc; rsp_id_seen = bus.rsp_id; rsp_msg_seen = bus.rsp_msg; rsp_err_seen = bus.rsp_err;
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      check("rsp_hold_valid", 256'(bus.rsp_valid), 256'(1));
      check("rsp_hold_msg", bus.rsp_msg, want_msg);
    end
    bus.rsp_ready = 1'b1;
    ack_cyc = cyc;
    @(posedge clk); #1;
    bus.rsp_ready = 1'b0;
  endtask

  task automatic do_reset();
    @(posedge clk); #1 reset = 1'b1;
    @(negedge clk);
    @(posedge clk); #1 reset = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got running want finished");
    $fatal(1);
  end

  initial begin
    bus.req0_valid = 1'b0; bus.req1_valid = 1'b0; bus.rsp_ready = 1'b0;
    bus.req0_p = '0; bus.req0_q = '0; bus.req0_mode = 1'b0; bus.req0_msg = '0;
    bus.req1_p = '0; bus.req1_q = '0; bus.req1_mode = 1'b0; bus.req1_msg = '0;
    repeat (3) @(negedge clk);
    check("rst_ready0", 256'(bus.req0_ready), 256'(0));
    check("rst_ready1", 256'(bus.req1_ready), 256'(0));
    check("rst_rsp_valid", 256'(bus.rsp_valid), 256'(0));
    check("rst_busy", 256'(bus.busy), 256'(0));
    check("rst_ctl_p", 256'(bus.ctl_p), 256'(0));
    check("rst_ctl_msg", bus.ctl_msg_in, 256'(0));
    check("rst_rsp_msg", bus.rsp_msg, 256'(0));
    @(posedge clk); #1 reset = 1'b0;

    // Basic encrypt
    lat = 20; i0 = inv_pulses; e0 = exp_pulses; r0 = ready_cycles;
    send_req(0, KP, KQ, 1'b0, MSG1);
    wait_any();
    check("basic_gid", 256'(grant_id), 256'(0));
    wait_rsp(2, ~MSG1);
    check("basic_inv_cnt", 256'(inv_pulses - i0), 256'(1));
    check("basic_exp_cnt", 256'(exp_pulses - e0), 256'(1));
    check("basic_ready_len", 256'(ready_cycles - r0), 256'(1));
    check("basic_inv_at", 256'(last_inv_cyc - grant_cyc), 256'(1));
    check("basic_exp_at", 256'(last_exp_cyc - last_inv_cyc), 256'(21));
    check("basic_rsp_at", 256'(rsp_cyc - last_exp_cyc), 256'(21));
    check("basic_rsp_id", 256'(rsp_id_seen), 256'(0));
    check("basic_rsp_msg", rsp_msg_seen, ~MSG1);
    check("basic_rsp_err", 256'(rsp_err_seen), 256'(0));
    check("basic_ctl_p", 256'(bus.ctl_p), 256'(KP));
    check("basic_ctl_q", 256'(bus.ctl_q), 256'(KQ));
    @(negedge clk);
    check("basic_idle_busy", 256'(bus.busy), 256'(0));

    // Key reuse
    i0 = inv_pulses;
    send_req(1, KP, KQ, 1'b1, MSG2);
    wait_any();
    check("reuse_gid", 256'(grant_id), 256'(1));
    wait_rsp(0, ~MSG2);
    check("reuse_no_inv", 256'(inv_pulses - i0), 256'(0));
    check("reuse_exp_at", 256'(last_exp_cyc - grant_cyc), 256'(1));
    check("reuse_rsp_id", 256'(rsp_id_seen), 256'(1));
    check("reuse_rsp_msg", rsp_msg_seen, ~MSG2);
    check("reuse_mode", 256'(bus.ctl_encrypt_decrypt), 256'(1));

    // Stale mod_exp finish from the previous job
    lat = 6; stale_hold = 1'b1;
    send_req(0, KP, KQ, 1'b0, MSG3);
    wait_any();
    wait_rsp(0, ~MSG3);
    stale_hold = 1'b0;
    check("stale_rsp_at", 256'(rsp_cyc - last_exp_cyc), 256'(7));
    check("stale_rsp_msg", rsp_msg_seen, ~MSG3);

    // Reset during EXP_WAIT
    lat = 30;
    send_req(0, KP2, KQ2, 1'b0, MSG1);
    wait_any();
    begin
      int n = 0;
      @(negedge clk);
      while (!bus.ctl_reset_mod_exp && n < 200) begin @(negedge clk); n++; end
      check("midrst_exp_seen", 256'(bus.ctl_reset_mod_exp), 256'(1));
    end
    @(posedge clk); #1;
    check("midrst_busy_before", 256'(bus.busy), 256'(1));
    #1 reset = 1'b1;
    #1;
    check("midrst_busy", 256'(bus.busy), 256'(0));
    check("midrst_ctl_p", 256'(bus.ctl_p), 256'(0));
    check("midrst_ctl_msg", bus.ctl_msg_in, 256'(0));
    check("midrst_rsp_valid", 256'(bus.rsp_valid), 256'(0));
    @(negedge clk);
    @(posedge clk); #1 reset = 1'b0;
    lat = 5; i0 = inv_pulses;
    send_req(0, KP2, KQ2, 1'b0, MSG2);
    wait_any();
    wait_rsp(0, ~MSG2);
    check("midrst_inv_again", 256'(inv_pulses - i0), 256'(1));
    check("midrst_rsp_msg", rsp_msg_seen, ~MSG2);

    // Round-robin arbitration after reset, twice
    do_reset();
    lat = 4;
    for (int pair = 0; pair < 2; pair++) begin
      send_req(0, KP, KQ, 1'b0, MSG1);
      send_req(1, KP2, KQ2, 1'b1, MSG2);
      wait_any();
      g_first = grant_id;
      check("arb_first", 256'(g_first), 256'(0));
      wait_rsp(0, ~MSG1);
      check("arb_first_rsp_id", 256'(rsp_id_seen), 256'(0));
      check("arb_first_msg", rsp_msg_seen, ~MSG1);
      wait_any();
      check("arb_second", 256'(grant_id), 256'(1));
      check("arb_wait_busy", 256'(grant_cyc > ack_cyc), 256'(1));
      wait_rsp(0, ~MSG2);
      check("arb_second_rsp_id", 256'(rsp_id_seen), 256'(1));
      check("arb_second_msg", rsp_msg_seen, ~MSG2);
    end

`ifdef RSA_SEQ_TIMEOUT_EN
    // Inverter never finishes: abort after 16 cycles in INV_WAIT
    do_reset();
    lat = 5; inv_en = 1'b0;
    send_req(1, KP, KQ, 1'b0, MSG1);
    wait_any();
    wait_rsp(0, 256'(0));
    inv_en = 1'b1;
    check("to_rsp_err", 256'(rsp_err_seen), 256'(1));
    check("to_rsp_msg", rsp_msg_seen, 256'(0));
    check("to_rsp_id", 256'(rsp_id_seen), 256'(1));
    check("to_rsp_at", 256'(rsp_cyc - last_inv_cyc), 256'(17));
`endif

    repeat (2) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/rsa_job_sequencer.md
RSA_JOB_SEQUENCER -- requirements
Module: rsa_job_sequencer

Interface
REQ-001 The block SHALL have parameter WIDTH, default 128, giving the width of the prime operands; messages are 2*WIDTH bits.
REQ-002 The block SHALL have parameter TIMEOUT_CYCLES, default 65536, giving the watchdog limit per RSA phase.
REQ-003 The block SHALL have these ports, with clock and reset first:
- clk  in  1  sole clock, rising edge.
- reset  in  1  asynchronous, active-high.
- reqN_valid  in  1  requester N (N=0,1) offers a job.
- reqN_ready  out  1  job accepted when valid and ready are both high.
- reqN_p, reqN_q  in  WIDTH  primes.
- reqN_mode  in  1  encrypt_decrypt value for the job.
- reqN_msg  in  2*WIDTH  message.
- rsp_valid  out  1  result available.
- rsp_ready  in  1  consumer accepts the result.
- rsp_id  out  1  requester index of the result.
- rsp_msg  out  2*WIDTH  result message.
- rsp_err  out  1  job aborted by the watchdog.
- ctl_p, ctl_q  out  WIDTH  primes to the control unit.
- ctl_encrypt_decrypt  out  1  mode to the control unit.
- ctl_msg_in  out  2*WIDTH  message to the control unit.
- ctl_reset_inverter, ctl_reset_mod_exp  out  1  phase start pulses.
- ctl_inverter_finish, ctl_mod_exp_finish  in  1  phase done flags from the control unit.
- ctl_msg_out  in  2*WIDTH  result from the control unit.
- busy  out  1  high in every state other than IDLE.

Function
REQ-004 FSM states SHALL be IDLE, INV_PULSE, INV_WAIT, EXP_PULSE, EXP_WAIT and RESP.
REQ-005 In IDLE, when any reqN_valid is high, the block SHALL grant one requester by round-robin:
- the requester not granted last wins a tie;
- after reset, requester 0 wins.
REQ-006 reqN_ready SHALL be a one-cycle pulse, asserted only in IDLE for the granted requester.
REQ-007 On the grant, p, q, mode and msg SHALL be latched into ctl_* and held stable until the next grant.
REQ-008 Phase sequencing SHALL be as follows:
- INV_PULSE drives ctl_reset_inverter high for exactly 1 cycle, then goes to INV_WAIT.
- EXP_PULSE drives ctl_reset_mod_exp high for exactly 1 cycle, then goes to EXP_WAIT.
REQ-009 Finish flags SHALL be ignored in the first cycle of each WAIT state, because stale flags from a previous job may still be high; they are sampled from the second cycle on.
REQ-010 INV_WAIT SHALL move to EXP_PULSE on a sampled ctl_inverter_finish.
REQ-011 EXP_WAIT SHALL move to RESP on a sampled ctl_mod_exp_finish, capturing ctl_msg_out into rsp_msg in the same edge.
REQ-012 Key reuse: when the granted p and q equal the last key whose inverter phase completed, the block SHALL go straight from grant to EXP_PULSE, skipping the inverter phase.
REQ-013 The key-reuse flag SHALL be cleared by reset and by any watchdog abort.
REQ-014 RESP SHALL hold rsp_valid high with rsp_msg, rsp_id and rsp_err stable until rsp_ready is high, then return to IDLE.
REQ-015 A new grant SHALL NOT occur in the same cycle as the rsp handshake.
REQ-016 When reqN_valid is raised while busy is high, the request SHALL wait and SHALL NOT be lost or granted early.

Reset
REQ-017 Asserting reset at any time, including mid-phase, SHALL force IDLE asynchronously.
REQ-018 While reset is high, the following outputs SHALL be 0: reqN_ready, rsp_valid, rsp_err, rsp_id, rsp_msg, ctl_* and busy.
REQ-019 Reset SHALL also clear the key-reuse flag and set the round-robin pointer so that requester 0 wins next.

Configuration
REQ-020 The macro RSA_SEQ_TIMEOUT_EN SHALL control the per-phase watchdog.
REQ-021 With RSA_SEQ_TIMEOUT_EN defined:
- a counter SHALL run in INV_WAIT and in EXP_WAIT;
- after TIMEOUT_CYCLES cycles without a finish, the FSM SHALL go to RESP with rsp_err=1 and rsp_msg=0.
REQ-022 Without RSA_SEQ_TIMEOUT_EN, the WAIT states SHALL wait indefinitely, rsp_err SHALL be tied to 0, and no counter logic SHALL be synthesized.

Verification
REQ-023 The bench SHALL cover these directed scenarios:
- Basic encrypt: req0 with p=113680897410347, q=7999808077935876437321, mode=0, msg=0x00262d806a3e18f03ab37b2857e7e100, model finish after 20 cycles -> one inverter pulse, then one mod_exp pulse, then rsp_valid with rsp_id=0 and rsp_msg equal to the model ctl_msg_out.
- Key reuse: req1 with the same p and q and msg=0x00262d806a3e18f03ab3000000000000 -> no ctl_reset_inverter pulse; ctl_reset_mod_exp pulses 1 cycle after the grant.
- Arbitration: req0 and req1 valid in the same cycle after reset -> req0 granted first, then req1; the next simultaneous pair grants req0 again.
- Stale finish: ctl_mod_exp_finish held high from the prior job -> it is ignored in the first EXP_WAIT cycle and no early rsp_valid occurs.
- Reset mid-phase: reset asserted during EXP_WAIT -> outputs 0 immediately; the next job with the same key runs the inverter phase.
- Timeout (RSA_SEQ_TIMEOUT_EN, TIMEOUT_CYCLES=16): finish never asserted -> rsp_valid with rsp_err=1 after 16 cycles in INV_WAIT.
